// File: rtl/pcint_pkg.sv
// Shared constants for the pin-change interrupt controller.
package pcint_pkg;

    localparam int unsigned NUM_GRP = 4;

    localparam int unsigned GRP_B = 0;
    localparam int unsigned GRP_C = 1;
    localparam int unsigned GRP_D = 2;
    localparam int unsigned GRP_E = 3;

    localparam int unsigned WIDTH_B = 8;
    localparam int unsigned WIDTH_C = 7;
    localparam int unsigned WIDTH_D = 8;
    localparam int unsigned WIDTH_E = 4;

    localparam logic [5:0] DEF_PCIFR_IO_ADDR  = 6'h1B;
    localparam logic [7:0] DEF_PCICR_DM_ADDR  = 8'h68;
    localparam logic [7:0] DEF_PCMSK0_DM_ADDR = 8'h6B;
    localparam logic [7:0] DEF_PCMSK1_DM_ADDR = 8'h6C;
    localparam logic [7:0] DEF_PCMSK2_DM_ADDR = 8'h6D;
    localparam logic [7:0] DEF_PCMSK3_DM_ADDR = 8'h73;

endpackage

// File: rtl/pcint_group.sv
// One pin-change group: input synchronizer, change detect, masked OR and PCIF flag.
module pcint_group #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] mask,
    input  logic             ack,
    input  logic             sw_clr,
    output logic             flag
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] s;
    logic             ev;

    assign s  = sync_q[SYNC_STAGES-1];
    assign ev = |((s ^ prev_q) & mask);

    // Synchronizer chain and previous-value tracker (tracks regardless of mask).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= s;
        end
    end

    // Flag: a detected event beats any simultaneous acknowledge or software clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag <= 1'b0;
        end else if (ev) begin
            flag <= 1'b1;
        end else if (ack) begin
            flag <= 1'b0;
        end else if (sw_clr) begin
            flag <= 1'b0;
        end
    end

endmodule

// File: rtl/pcint_ctrl.sv
// Pin-change interrupt controller for ports B/C/D/E: register file, read muxes, group instances.
module pcint_ctrl
    import pcint_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter logic [5:0]  PCIFR_IO_ADDR  = DEF_PCIFR_IO_ADDR,
    parameter logic [7:0]  PCICR_DM_ADDR  = DEF_PCICR_DM_ADDR,
    parameter logic [7:0]  PCMSK0_DM_ADDR = DEF_PCMSK0_DM_ADDR,
    parameter logic [7:0]  PCMSK1_DM_ADDR = DEF_PCMSK1_DM_ADDR,
    parameter logic [7:0]  PCMSK2_DM_ADDR = DEF_PCMSK2_DM_ADDR,
    parameter logic [7:0]  PCMSK3_DM_ADDR = DEF_PCMSK3_DM_ADDR
) (
    input  logic       cp2,
    input  logic       ireset,
    input  logic [5:0] IO_Addr,
    input  logic       iore,
    input  logic       iowe,
    input  logic [7:0] dbus_in,
    output logic [7:0] dbus_out,
    output logic       out_en,
    input  logic [7:0] ramadr,
    input  logic       ramre,
    input  logic       ramwe,
    output logic [7:0] dm_dbus_out,
    output logic       dm_out_en,
    input  logic [7:0] DIB_i,
    input  logic [6:0] DIC_i,
    input  logic [7:0] DID_i,
    input  logic [3:0] DIE_i,
    output logic [7:0] PCINT_B,
    output logic [6:0] PCINT_C,
    output logic [7:0] PCINT_D,
    output logic [3:0] PCINT_E,
    output logic [3:0] PCIE,
    output logic [3:0] pcint_irq,
    input  logic [3:0] pcint_ack
);

    logic [3:0] pcicr_q;
    logic [7:0] pcmsk0_q;
    logic [6:0] pcmsk1_q;
    logic [7:0] pcmsk2_q;
    logic [3:0] pcmsk3_q;
    logic [NUM_GRP-1:0] pcif;
    logic [NUM_GRP-1:0] sw_clr;
    logic pcifr_hit;

    assign pcifr_hit = (IO_Addr == PCIFR_IO_ADDR);
    assign sw_clr    = (iowe && pcifr_hit) ? dbus_in[NUM_GRP-1:0] : '0;

    // Control and mask registers; unimplemented bits are simply not stored.
    always_ff @(posedge cp2) begin
        if (!ireset) begin
            pcicr_q  <= '0;
            pcmsk0_q <= '0;
            pcmsk1_q <= '0;
            pcmsk2_q <= '0;
            pcmsk3_q <= '0;
        end else if (ramwe) begin
            if (ramadr == PCICR_DM_ADDR)  pcicr_q  <= dbus_in[3:0];
            if (ramadr == PCMSK0_DM_ADDR) pcmsk0_q <= dbus_in;
            if (ramadr == PCMSK1_DM_ADDR) pcmsk1_q <= dbus_in[6:0];
            if (ramadr == PCMSK2_DM_ADDR) pcmsk2_q <= dbus_in;
            if (ramadr == PCMSK3_DM_ADDR) pcmsk3_q <= dbus_in[3:0];
        end
    end

    pcint_group #(.WIDTH(WIDTH_B), .SYNC_STAGES(SYNC_STAGES)) u_grp_b (
        .clk(cp2), .rst_n(ireset), .din(DIB_i), .mask(pcmsk0_q),
        .ack(pcint_ack[GRP_B]), .sw_clr(sw_clr[GRP_B]), .flag(pcif[GRP_B])
    );
    pcint_group #(.WIDTH(WIDTH_C), .SYNC_STAGES(SYNC_STAGES)) u_grp_c (
        .clk(cp2), .rst_n(ireset), .din(DIC_i), .mask(pcmsk1_q),
        .ack(pcint_ack[GRP_C]), .sw_clr(sw_clr[GRP_C]), .flag(pcif[GRP_C])
    );
    pcint_group #(.WIDTH(WIDTH_D), .SYNC_STAGES(SYNC_STAGES)) u_grp_d (
        .clk(cp2), .rst_n(ireset), .din(DID_i), .mask(pcmsk2_q),
        .ack(pcint_ack[GRP_D]), .sw_clr(sw_clr[GRP_D]), .flag(pcif[GRP_D])
    );
    pcint_group #(.WIDTH(WIDTH_E), .SYNC_STAGES(SYNC_STAGES)) u_grp_e (
        .clk(cp2), .rst_n(ireset), .din(DIE_i), .mask(pcmsk3_q),
        .ack(pcint_ack[GRP_E]), .sw_clr(sw_clr[GRP_E]), .flag(pcif[GRP_E])
    );

    assign PCINT_B   = pcmsk0_q;
    assign PCINT_C   = pcmsk1_q;
    assign PCINT_D   = pcmsk2_q;
    assign PCINT_E   = pcmsk3_q;
    assign PCIE      = pcicr_q;
    assign pcint_irq = pcif & pcicr_q;

    // I/O-space read of PCIFR.
    always_comb begin
        out_en   = iore && pcifr_hit;
        dbus_out = 8'h00;
        if (out_en) dbus_out = {4'h0, pcif};
    end

    // Data-memory read mux for PCICR and the mask registers.
    always_comb begin
        dm_out_en   = 1'b0;
        dm_dbus_out = 8'h00;
        if (ramre) begin
            dm_out_en = 1'b1;
            if (ramadr == PCICR_DM_ADDR)       dm_dbus_out = {4'h0, pcicr_q};
            else if (ramadr == PCMSK0_DM_ADDR) dm_dbus_out = pcmsk0_q;
            else if (ramadr == PCMSK1_DM_ADDR) dm_dbus_out = {1'b0, pcmsk1_q};
            else if (ramadr == PCMSK2_DM_ADDR) dm_dbus_out = pcmsk2_q;
            else if (ramadr == PCMSK3_DM_ADDR) dm_dbus_out = {4'h0, pcmsk3_q};
            else                               dm_out_en   = 1'b0;
        end
    end

endmodule

// File: tb/tb_pcint_ctrl.sv
// Directed bench for pcint_ctrl with hand-computed expectations.
module tb_pcint_ctrl;

    logic       cp2 = 1'b0;
    logic       ireset;
    logic [5:0] IO_Addr;
    logic       iore, iowe;
    logic [7:0] dbus_in;
    logic [7:0] dbus_out;
    logic       out_en;
    logic [7:0] ramadr;
    logic       ramre, ramwe;
    logic [7:0] dm_dbus_out;
    logic       dm_out_en;
    logic [7:0] DIB_i;
    logic [6:0] DIC_i;
    logic [7:0] DID_i;
    logic [3:0] DIE_i;
    logic [7:0] PCINT_B;
    logic [6:0] PCINT_C;
    logic [7:0] PCINT_D;
    logic [3:0] PCINT_E;
    logic [3:0] PCIE;
    logic [3:0] pcint_irq;
    logic [3:0] pcint_ack;

    int checks = 0;
    int errors = 0;

    pcint_ctrl dut (
        .cp2(cp2), .ireset(ireset), .IO_Addr(IO_Addr), .iore(iore), .iowe(iowe),
        .dbus_in(dbus_in), .dbus_out(dbus_out), .out_en(out_en),
        .ramadr(ramadr), .ramre(ramre), .ramwe(ramwe),
        .dm_dbus_out(dm_dbus_out), .dm_out_en(dm_out_en),
        .DIB_i(DIB_i), .DIC_i(DIC_i), .DID_i(DID_i), .DIE_i(DIE_i),
        .PCINT_B(PCINT_B), .PCINT_C(PCINT_C), .PCINT_D(PCINT_D), .PCINT_E(PCINT_E),
        .PCIE(PCIE), .pcint_irq(pcint_irq), .pcint_ack(pcint_ack)
    );

    always #5 cp2 = ~cp2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge cp2);
        #1;
    endtask

    task automatic dm_wr(input logic [7:0] a, input logic [7:0] d);
        ramadr = a; dbus_in = d; ramwe = 1'b1;
        tick();
        ramwe = 1'b0;
    endtask

    task automatic io_wr(input logic [7:0] d);
        IO_Addr = 6'h1B; dbus_in = d; iowe = 1'b1;
        tick();
        iowe = 1'b0;
    endtask

    task automatic dm_rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
        ramadr = a; ramre = 1'b1;
        #1;
        chk(tag, 32'(dm_dbus_out), 32'(exp));
        chk({tag, "_en"}, 32'(dm_out_en), 32'd1);
        ramre = 1'b0;
        #1;
    endtask

    task automatic io_rd(input string tag, input logic [7:0] exp);
        IO_Addr = 6'h1B; iore = 1'b1;
        #1;
        chk(tag, 32'(dbus_out), 32'(exp));
        chk({tag, "_en"}, 32'(out_en), 32'd1);
        iore = 1'b0;
        #1;
    endtask

    initial begin
        ireset = 1'b0; IO_Addr = '0; iore = 0; iowe = 0; dbus_in = '0;
        ramadr = '0; ramre = 0; ramwe = 0;
        DIB_i = '0; DIC_i = '0; DID_i = '0; DIE_i = '0; pcint_ack = '0;
        tick(); tick();

        // 1. Reset state
        chk("rst_irq", 32'(pcint_irq), 32'h0);
        chk("rst_pcie", 32'(PCIE), 32'h0);
        chk("rst_pcint", 32'({PCINT_B, 1'b0, PCINT_C, PCINT_D, 4'h0, PCINT_E}), 32'h0);
        chk("rst_rdbus", 32'({dbus_out, out_en, dm_dbus_out, dm_out_en}), 32'h0);
        ireset = 1'b1;
        tick();
        io_rd("rst_pcifr", 8'h00);
        dm_rd("rst_pcicr", 8'h68, 8'h00);
        dm_rd("rst_pcmsk0", 8'h6B, 8'h00);
        dm_rd("rst_pcmsk1", 8'h6C, 8'h00);
        dm_rd("rst_pcmsk2", 8'h6D, 8'h00);
        dm_rd("rst_pcmsk3", 8'h73, 8'h00);
        ramadr = 8'h69; ramre = 1'b1; #1;
        chk("dm_miss_en", 32'(dm_out_en), 32'd0);
        chk("dm_miss_data", 32'(dm_dbus_out), 32'd0);
        ramre = 1'b0;

        // 2. Masked C3 rising, exact latency, then ack
        dm_wr(8'h6C, 8'h08);
        dm_wr(8'h68, 8'h02);
        chk("pcint_c", 32'(PCINT_C), 32'h08);
        chk("pcie_c", 32'(PCIE), 32'h2);
        DIC_i[3] = 1'b1;
        tick();
        chk("c3_edge1_irq", 32'(pcint_irq), 32'h0);
        tick();
        chk("c3_edge2_irq", 32'(pcint_irq), 32'h0);
        io_rd("c3_edge2_pcifr", 8'h00);
        tick();
        chk("c3_edge3_irq", 32'(pcint_irq), 32'h2);
        io_rd("c3_edge3_pcifr", 8'h02);
        pcint_ack = 4'b0010;
        tick();
        pcint_ack = '0;
        chk("c3_ack_irq", 32'(pcint_irq), 32'h0);
        io_rd("c3_ack_pcifr", 8'h00);

        // 3. Unmasked pin, then masked pin with group disabled
        DIC_i[2] = 1'b1;
        repeat (4) tick();
        io_rd("c2_unmasked", 8'h00);
        dm_wr(8'h68, 8'h00);
        DIC_i[3] = 1'b0;
        repeat (3) tick();
        io_rd("c3_dis_pcifr", 8'h02);
        chk("c3_dis_irq", 32'(pcint_irq), 32'h0);
        dm_wr(8'h68, 8'h02);
        chk("c3_en_irq", 32'(pcint_irq), 32'h2);
        pcint_ack = 4'b0010;
        tick();
        pcint_ack = '0;

        // 4. Software clear of B and D flags
        dm_wr(8'h6B, 8'h01);
        dm_wr(8'h6D, 8'h01);
        DIB_i[0] = 1'b1; DID_i[0] = 1'b1;
        repeat (3) tick();
        io_rd("bd_pcifr", 8'h05);
        chk("bd_irq", 32'(pcint_irq), 32'h0);
        io_wr(8'h04);
        io_rd("bd_clr4", 8'h01);
        io_wr(8'h00);
        io_rd("bd_clr0", 8'h01);
        io_wr(8'h01);
        io_rd("bd_clr1", 8'h00);

        // 5. Event wins over simultaneous ack on group E
        dm_wr(8'h73, 8'h01);
        dm_wr(8'h68, 8'h08);
        DIE_i[0] = 1'b1;
        repeat (3) tick();
        chk("e_first_irq", 32'(pcint_irq), 32'h8);
        DIE_i[0] = 1'b0;
        tick(); tick();
        pcint_ack = 4'b1000;
        tick();
        pcint_ack = '0;
        io_rd("e_setwins_pcifr", 8'h08);
        chk("e_setwins_irq", 32'(pcint_irq), 32'h8);

        // 6. Unimplemented bits, then reset while irq pending
        dm_wr(8'h6C, 8'hFF);
        dm_wr(8'h73, 8'hFF);
        dm_wr(8'h68, 8'hFF);
        dm_rd("ui_pcmsk1", 8'h6C, 8'h7F);
        dm_rd("ui_pcmsk3", 8'h73, 8'h0F);
        dm_rd("ui_pcicr", 8'h68, 8'h0F);
        chk("ui_pcie", 32'(PCIE), 32'hF);
        chk("pre_rst_irq", 32'(pcint_irq), 32'h8);
        ireset = 1'b0;
        tick();
        chk("mid_rst_irq", 32'(pcint_irq), 32'h0);
        chk("mid_rst_pcie", 32'(PCIE), 32'h0);
        chk("mid_rst_pcint", 32'({PCINT_B, 1'b0, PCINT_C, PCINT_D, 4'h0, PCINT_E}), 32'h0);
        ireset = 1'b1;
        tick();
        io_rd("post_rst_pcifr", 8'h00);
        dm_rd("post_rst_pcmsk1", 8'h6C, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
